// File: rtl/step_gen_pkg.sv
// ============================================================================
//  Module      : step_gen_pkg
//  Description : Shared defaults and counter-width helper for step_pulse_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package step_gen_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int AUTO_DIV_DEF        = 1000;
    localparam int REPEAT_DELAY_DEF    = 500;
    localparam int REPEAT_PERIOD_DEF   = 100;

    // Bits needed to hold 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((64'd1 << w) < 64'(n))
            w = w + 1;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
//  Module      : btn_debounce
//  Description : Two-flop synchroniser followed by a consecutive-sample filter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce
    import step_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level
);

    localparam int                  c_cnt_w    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);

    logic               r_s1;
    logic               r_s2;
    logic               r_level;
    logic [c_cnt_w-1:0] r_cnt;

    // The counter only runs while the synchronised input disagrees with the
    // accepted level, so it saturates at c_cnt_last and can never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1 <= btn_in;
            r_s2 <= r_s1;
            if (r_s2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_level <= r_s2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    assign btn_level = r_level;

endmodule

`default_nettype wire

// File: rtl/step_pulse_gen.sv
// ============================================================================
//  Module      : step_pulse_gen
//  Description : Debounced button / prescaler step-pulse source for the counter.
//                Optional hold-to-repeat enabled by macro STEP_AUTOREPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_pulse_gen
    import step_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int AUTO_DIV        = AUTO_DIV_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic auto_en,
    output logic step_out,
    output logic btn_level
);

    localparam int                  c_pre_w    = cnt_width(AUTO_DIV);
    localparam logic [c_pre_w-1:0]  c_pre_last = c_pre_w'(AUTO_DIV - 1);
    localparam logic [c_pre_w-1:0]  c_pre_one  = c_pre_w'(1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 || AUTO_DIV < 2 ||
        AUTO_DIV > 16777215 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 2) begin : g_param_check
        $error("step_pulse_gen: parameter out of legal range");
    end

    logic               w_level;
    logic               w_press;
    logic               w_tick;
    logic               w_repeat;
    logic               w_step_req;
    logic               r_level_d;
    logic [c_pre_w-1:0] r_pre;
    logic               r_step;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_level (w_level)
    );

    assign w_press = w_level & ~r_level_d;
    assign w_tick  = auto_en & (r_pre == c_pre_last);

`ifdef STEP_AUTOREPEAT_EN
    localparam int c_hold_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int                   c_hold_w   = cnt_width(c_hold_max + 1);
    localparam logic [c_hold_w-1:0]  c_delay    = c_hold_w'(REPEAT_DELAY);
    localparam logic [c_hold_w-1:0]  c_period   = c_hold_w'(REPEAT_PERIOD);
    localparam logic [c_hold_w-1:0]  c_hold_one = c_hold_w'(1);

    logic [c_hold_w-1:0] r_hold;
    logic                r_armed;

    // r_hold == 0 means idle; after a press or repeat it restarts at 1 and
    // fires when it reaches the delay (first repeat) or the period (later).
    assign w_repeat = w_level & ~auto_en & (r_hold != '0) &
                      (r_hold == (r_armed ? c_period : c_delay));

    always_ff @(posedge clk) begin
        if (rst || !w_level || auto_en) begin
            r_hold  <= '0;
            r_armed <= 1'b0;
        end else if (w_press || w_repeat) begin
            r_hold  <= c_hold_one;
            r_armed <= w_repeat;
        end else if (r_hold != '0) begin
            r_hold <= r_hold + c_hold_one;
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    assign w_step_req = ((w_press | w_repeat) & ~auto_en) | w_tick;

    // The ~r_step term keeps pulses apart across a same-cycle mode change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level_d <= 1'b0;
            r_pre     <= '0;
            r_step    <= 1'b0;
        end else begin
            r_level_d <= w_level;
            if (!auto_en || w_tick)
                r_pre <= '0;
            else
                r_pre <= r_pre + c_pre_one;
            r_step <= w_step_req & ~r_step;
        end
    end

    assign step_out  = r_step;
    assign btn_level = w_level;

endmodule

`default_nettype wire
